// File: rtl/niosii_system_switch_event_ctrl.sv
// rtl/niosii_system_switch_event_ctrl.sv - switch PIO irq service engine with event FIFO
module niosii_system_switch_event_ctrl #(
  parameter int             W          = 4,
  parameter logic [W-1:0]   IRQ_MASK   = 4'hF,
  parameter int             FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  output logic [1:0]    pio_address,
  output logic          pio_chipselect,
  output logic          pio_write_n,
  output logic [31:0]   pio_writedata,
  input  logic [31:0]   pio_readdata,
  input  logic          pio_irq,
  output logic          evt_valid,
  input  logic          evt_ready,
  output logic [W-1:0]  evt_edges,
  output logic [W-1:0]  evt_level,
  output logic [15:0]   evt_count,
  output logic          overflow,
  input  logic          overflow_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_RST, S_CFG, S_WAIT, S_RDCAP, S_CLR, S_RDDAT, S_PUSH
  } state_t;

  state_t          state_q, state_d;
  logic            cfg_done_q, cfg_done_d;
  logic [W-1:0]    cap_q, cap_d;
  logic            push_req;

  logic [2*W-1:0]  mem_q [FIFO_DEPTH];
  logic [AW:0]     wr_ptr_q, rd_ptr_q;
  logic [15:0]     count_q;
  logic            overflow_q;
  logic            fifo_empty, fifo_full, pop, push_acc;

  // Upper readdata bits are never used by a W-bit PIO.
  logic            unused_rd;
  assign unused_rd = ^pio_readdata[31:W];

  // State, config flag and captured edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_RST;
      cfg_done_q <= 1'b0;
      cap_q      <= '0;
    end else begin
      state_q    <= state_d;
      cfg_done_q <= cfg_done_d;
      cap_q      <= cap_d;
    end
  end

  // Next state and Avalon-MM bus drive; the bus idles outside the access states.
  always_comb begin
    state_d        = state_q;
    cfg_done_d     = cfg_done_q;
    cap_d          = cap_q;
    push_req       = 1'b0;
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_address    = 2'd0;
    pio_writedata  = 32'd0;
    case (state_q)
      S_RST: begin
        if (enable) state_d = cfg_done_q ? S_WAIT : S_CFG;
      end
      S_CFG: begin
        pio_chipselect = 1'b1;
        pio_write_n    = 1'b0;
        pio_address    = 2'd2;
        pio_writedata  = {{(32-W){1'b0}}, IRQ_MASK};
        cfg_done_d     = 1'b1;
        state_d        = S_WAIT;
      end
      S_WAIT: begin
        if (enable && pio_irq) state_d = S_RDCAP;
      end
      S_RDCAP: begin
        pio_chipselect = 1'b1;
        pio_address    = 2'd3;
        state_d        = S_CLR;
      end
      S_CLR: begin
        cap_d          = pio_readdata[W-1:0];
        pio_chipselect = 1'b1;
        pio_write_n    = 1'b0;
        pio_address    = 2'd3;
        state_d        = S_RDDAT;
      end
      S_RDDAT: begin
        pio_chipselect = 1'b1;
        pio_address    = 2'd0;
        state_d        = S_PUSH;
      end
      S_PUSH: begin
        // A zero capture is a spurious interrupt and produces no event.
        push_req = (cap_q != '0);
        state_d  = S_WAIT;
      end
      default: state_d = S_RST;
    endcase
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = !fifo_empty && evt_ready;
  assign push_acc   = push_req && (!fifo_full || pop);

  // FIFO pointers, event counter and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_acc && (count_q != 16'hFFFF)) count_q <= count_q + 16'd1;
      if (push_req && !push_acc) overflow_q <= 1'b1;
      else if (overflow_clr) overflow_q <= 1'b0;
    end
  end

  // Event storage; contents are only visible while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q[AW-1:0]] <= {cap_q, pio_readdata[W-1:0]};
  end

  assign evt_valid = !fifo_empty;
  assign evt_edges = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]][2*W-1:W];
  assign evt_level = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]][W-1:0];
  assign evt_count = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_niosii_system_switch_event_ctrl.sv
// tb/tb_niosii_system_switch_event_ctrl.sv - directed bench for the switch event controller
module tb_niosii_system_switch_event_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata = '0;
  logic        pio_irq;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [3:0]  evt_edges;
  logic [3:0]  evt_level;
  logic [15:0] evt_count;
  logic        overflow;
  logic        overflow_clr = 1'b0;

  // PIO slave model
  logic [3:0]  sl_level = '0;
  logic [3:0]  sl_mask = '0;
  logic [3:0]  sl_cap = '0;
  logic [3:0]  set_req = '0;
  logic        zero_cap = 1'b0;
  logic        irq_force = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  niosii_system_switch_event_ctrl dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
    .pio_readdata(pio_readdata), .pio_irq(pio_irq),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_edges(evt_edges), .evt_level(evt_level),
    .evt_count(evt_count), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  assign pio_irq = (|(sl_cap & sl_mask)) | irq_force;

  always @(posedge clk) begin
    if (pio_chipselect && !pio_write_n && pio_address == 2'd2) sl_mask <= pio_writedata[3:0];
    sl_cap <= (pio_chipselect && !pio_write_n && pio_address == 2'd3) ? 4'h0 : (sl_cap | set_req);
    if (pio_chipselect && pio_write_n)
      case (pio_address)
        2'd0:    pio_readdata <= {28'd0, sl_level};
        2'd2:    pio_readdata <= {28'd0, sl_mask};
        2'd3:    pio_readdata <= zero_cap ? 32'd0 : {28'd0, sl_cap};
        default: pio_readdata <= 32'd0;
      endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic chk_bus(input string tag, input logic cs, input logic wn,
                         input logic [1:0] a, input logic [31:0] wd);
    chk({tag, "_cs"}, pio_chipselect, cs);
    chk({tag, "_wn"}, pio_write_n, wn);
    chk({tag, "_addr"}, pio_address, a);
    chk({tag, "_wd"}, pio_writedata, wd);
  endtask

  // Reset, release, and check the single config write one cycle later.
  task automatic do_reset;
    reset_n = 1'b0;
    step;
    chk_bus("rst_bus", 1'b0, 1'b1, 2'd0, 32'd0);
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_count", evt_count, 16'd0);
    chk("rst_ovf", overflow, 1'b0);
    reset_n = 1'b1;
    step;
    chk_bus("cfg", 1'b1, 1'b0, 2'd2, 32'h0000000F);
    step;
    chk_bus("cfg_idle", 1'b0, 1'b1, 2'd0, 32'd0);
    chk("cfg_mask", sl_mask, 4'hF);
  endtask

  // One edge interrupt serviced end-to-end; optionally pop during the PUSH cycle.
  task automatic fire(input logic [3:0] e, input logic [3:0] l, input bit pop_push);
    sl_level = l;
    set_req  = e;
    step;
    set_req  = '0;
    step; step; step; step;
    evt_ready = pop_push;
    step;
    evt_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_q [4];

    // 1: reset and configuration
    do_reset();

    // 2: single event, cycle by cycle
    sl_level = 4'b0100;
    set_req  = 4'b0101;
    step;
    set_req  = '0;
    chk("t2_irq", pio_irq, 1'b1);
    chk_bus("t2_wait", 1'b0, 1'b1, 2'd0, 32'd0);
    step; chk_bus("t2_rdcap", 1'b1, 1'b1, 2'd3, 32'd0);
    step; chk_bus("t2_clr",   1'b1, 1'b0, 2'd3, 32'd0);
    step; chk_bus("t2_rddat", 1'b1, 1'b1, 2'd0, 32'd0);
    step; chk_bus("t2_push",  1'b0, 1'b1, 2'd0, 32'd0);
    chk("t2_valid_k4", evt_valid, 1'b0);
    step;
    chk("t2_valid_k5", evt_valid, 1'b1);
    chk("t2_edges", evt_edges, 4'h5);
    chk("t2_level", evt_level, 4'h4);
    chk("t2_count", evt_count, 16'd1);
    chk("t2_cap_cleared", sl_cap, 4'h0);
    evt_ready = 1'b1;
    step;
    evt_ready = 1'b0;
    chk("t2_pop_valid", evt_valid, 1'b0);
    chk("t2_pop_edges", evt_edges, 4'h0);

    // 3: overflow on a full FIFO, push+pop on full, in-order drain
    do_reset();
    fire(4'h1, 4'h1, 1'b0);
    fire(4'h2, 4'h2, 1'b0);
    fire(4'h3, 4'h3, 1'b0);
    fire(4'h4, 4'h4, 1'b0);
    chk("t3_ovf_before", overflow, 1'b0);
    fire(4'h6, 4'h6, 1'b0);
    chk("t3_ovf", overflow, 1'b1);
    chk("t3_count4", evt_count, 16'd4);
    chk("t3_head1", evt_edges, 4'h1);
    fire(4'h9, 4'h9, 1'b1);
    chk("t3_count5", evt_count, 16'd5);
    exp_q = '{4'h2, 4'h3, 4'h4, 4'h9};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_valid%0d", i), evt_valid, 1'b1);
      chk($sformatf("t3_edges%0d", i), evt_edges, exp_q[i]);
      chk($sformatf("t3_level%0d", i), evt_level, exp_q[i]);
      evt_ready = 1'b1;
      step;
      evt_ready = 1'b0;
    end
    chk("t3_empty", evt_valid, 1'b0);
    chk("t3_ovf_sticky", overflow, 1'b1);
    overflow_clr = 1'b1;
    step;
    overflow_clr = 1'b0;
    chk("t3_ovf_clr", overflow, 1'b0);

    // 4: spurious irq, capture reads zero
    zero_cap  = 1'b1;
    irq_force = 1'b1;
    step;
    irq_force = 1'b0;
    chk_bus("t4_rdcap", 1'b1, 1'b1, 2'd3, 32'd0);
    step; step;
    chk_bus("t4_rddat", 1'b1, 1'b1, 2'd0, 32'd0);
    step; step;
    zero_cap = 1'b0;
    chk("t4_count", evt_count, 16'd5);
    chk("t4_valid", evt_valid, 1'b0);

    // 5: enable dropped mid-sequence
    sl_level = 4'h3;
    set_req  = 4'h8;
    step;
    set_req  = '0;
    step;
    enable = 1'b0;
    step; step; step; step;
    chk("t5_valid", evt_valid, 1'b1);
    chk("t5_edges", evt_edges, 4'h8);
    chk("t5_level", evt_level, 4'h3);
    chk("t5_count", evt_count, 16'd6);
    set_req = 4'h2;
    step;
    set_req = '0;
    for (int i = 0; i < 4; i++) begin
      step;
      chk($sformatf("t5_idle%0d", i), pio_chipselect, 1'b0);
    end
    chk("t5_pending", sl_cap, 4'h2);
    chk("t5_count_hold", evt_count, 16'd6);
    enable = 1'b1;
    step;
    chk_bus("t5_rdcap", 1'b1, 1'b1, 2'd3, 32'd0);
    step; step; step; step;
    chk("t5_count7", evt_count, 16'd7);

    // 6: asynchronous reset during CLR
    set_req = 4'h1;
    step;
    set_req = '0;
    step; step;
    chk_bus("t6_clr", 1'b1, 1'b0, 2'd3, 32'd0);
    reset_n = 1'b0;
    #1;
    chk_bus("t6_async", 1'b0, 1'b1, 2'd0, 32'd0);
    chk("t6_valid", evt_valid, 1'b0);
    chk("t6_count", evt_count, 16'd0);
    chk("t6_edges", evt_edges, 4'h0);
    step;
    reset_n = 1'b1;
    step;
    chk_bus("t6_cfg", 1'b1, 1'b0, 2'd2, 32'h0000000F);
    step;
    step; step; step; step; step;
    chk("t6_evt_valid", evt_valid, 1'b1);
    chk("t6_evt_edges", evt_edges, 4'h1);
    chk("t6_evt_count", evt_count, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
